// File: rtl/avalon_irq_register_bank_if.sv
// Avalon-MM bus bundle for the IRQ register bank: request side from the
// interconnect, read-return side back to it.
interface avalon_irq_register_bank_if #(
  parameter int DATAWIDTH = 32,
  parameter int REGS      = 8
);
  localparam int AW = $clog2(REGS);

  logic                   read;
  logic                   write;
  logic [AW-1:0]          address;
  logic [DATAWIDTH/8-1:0] byteenable;
  logic [DATAWIDTH-1:0]   data_in;
  logic                   read_valid;
  logic [DATAWIDTH-1:0]   data_out;

  modport master (
    output read, write, address, byteenable, data_in,
    input  read_valid, data_out
  );

  modport slave (
    input  read, write, address, byteenable, data_in,
    output read_valid, data_out
  );
endinterface

// File: rtl/avalon_irq_register_bank.sv
// Avalon-MM register bank with an edge-triggered interrupt controller.
// Map: 0 IRQ_STATUS (W1C), 1 IRQ_ENABLE, 2 IRQ_RAW (RO), 3.. scratch (RW).
// Reads are fully pipelined with a fixed latency and no waitrequest.
module avalon_irq_register_bank #(
  parameter int DATAWIDTH   = 32,
  parameter int REGS        = 8,
  parameter int LATENCY     = 1,
  parameter int IRQ_SOURCES = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  avalon_irq_register_bank_if.slave       bus,
  input  logic [IRQ_SOURCES-1:0]          irq_sources,
  output logic [(REGS-3)*DATAWIDTH-1:0]   scratch_out,
  output logic                            irq
);
  localparam int AW = $clog2(REGS);
  localparam int NB = DATAWIDTH / 8;
  localparam int NS = REGS - 3;

  logic [IRQ_SOURCES-1:0] src_q;
  logic [IRQ_SOURCES-1:0] irq_status;
  logic [IRQ_SOURCES-1:0] irq_enable;
  logic [IRQ_SOURCES-1:0] src_edge;
  logic [IRQ_SOURCES-1:0] w1c_bits;
  logic [DATAWIDTH-1:0]   scratch [NS];
  logic [DATAWIDTH-1:0]   be_mask;
  logic [DATAWIDTH-1:0]   rd_data;
  logic                   rd_accept;
  logic                   pipe_valid [LATENCY];
  logic [DATAWIDTH-1:0]   pipe_data  [LATENCY];

  // Expand byte enables into a per-bit write mask.
  always_comb begin
    be_mask = '0;
    for (int b = 0; b < NB; b++) begin
      be_mask[b*8 +: 8] = {8{bus.byteenable[b]}};
    end
  end

  assign src_edge  = irq_sources & ~src_q;
  assign rd_accept = bus.read & ~bus.write;
  assign w1c_bits  = (bus.write && bus.address == AW'(0)) ?
                     (bus.data_in[IRQ_SOURCES-1:0] & be_mask[IRQ_SOURCES-1:0]) : '0;

  // Interrupt state: edge detector, W1C status (a new edge beats a clear), enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_q      <= '0;
      irq_status <= '0;
      irq_enable <= '0;
    end else begin
      src_q      <= irq_sources;
      irq_status <= (irq_status & ~w1c_bits) | src_edge;
      if (bus.write && bus.address == AW'(1)) begin
        irq_enable <= (irq_enable & ~be_mask[IRQ_SOURCES-1:0]) |
                      (bus.data_in[IRQ_SOURCES-1:0] & be_mask[IRQ_SOURCES-1:0]);
      end
    end
  end

  // Scratch registers with byte-lane writes; unmatched addresses write nothing.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < NS; j++) begin
        scratch[j] <= '0;
      end
    end else if (bus.write) begin
      for (int j = 0; j < NS; j++) begin
        if (bus.address == AW'(j + 3)) begin
          scratch[j] <= (scratch[j] & ~be_mask) | (bus.data_in & be_mask);
        end
      end
    end
  end

  // Read mux from current (pre-update) state; out-of-range addresses give 0.
  always_comb begin
    rd_data = '0;
    if (bus.address == AW'(0)) begin
      rd_data[IRQ_SOURCES-1:0] = irq_status;
    end else if (bus.address == AW'(1)) begin
      rd_data[IRQ_SOURCES-1:0] = irq_enable;
    end else if (bus.address == AW'(2)) begin
      rd_data[IRQ_SOURCES-1:0] = irq_sources;
    end
    for (int j = 0; j < NS; j++) begin
      if (bus.address == AW'(j + 3)) begin
        rd_data = scratch[j];
      end
    end
  end

  // Read return pipeline; each data stage only loads with a valid, so the
  // last stage holds the most recent returned word between reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_valid[i] <= 1'b0;
        pipe_data[i]  <= '0;
      end
    end else begin
      pipe_valid[0] <= rd_accept;
      if (rd_accept) begin
        pipe_data[0] <= rd_data;
      end
      for (int i = 1; i < LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        if (pipe_valid[i-1]) begin
          pipe_data[i] <= pipe_data[i-1];
        end
      end
    end
  end

  assign bus.read_valid = pipe_valid[LATENCY-1];
  assign bus.data_out   = pipe_data[LATENCY-1];

  for (genvar j = 0; j < NS; j++) begin : g_scratch_out
    assign scratch_out[j*DATAWIDTH +: DATAWIDTH] = scratch[j];
  end

  assign irq = |(irq_status & irq_enable);
endmodule

// File: tb/tb_avalon_irq_register_bank.sv
// Bench for avalon_irq_register_bank: directed scenarios plus random traffic,
// all checked every cycle against a register-map level reference model.
module tb_avalon_irq_register_bank;
  localparam int DW   = 32;
  localparam int REGS = 8;
  localparam int LAT  = 2;
  localparam int NSRC = 4;
  localparam int AW   = $clog2(REGS);
  localparam int NS   = REGS - 3;
  localparam logic [DW-1:0] SRC_MASK = DW'((64'd1 << NSRC) - 1);

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NSRC-1:0]      irq_sources;
  logic [NS*DW-1:0]     scratch_out;
  logic                 irq;

  avalon_irq_register_bank_if #(.DATAWIDTH(DW), .REGS(REGS)) bus ();

  avalon_irq_register_bank #(
    .DATAWIDTH(DW), .REGS(REGS), .LATENCY(LAT), .IRQ_SOURCES(NSRC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .irq_sources(irq_sources),
    .scratch_out(scratch_out),
    .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rd_t;

  logic [DW-1:0]   m_reg [REGS];
  logic [NSRC-1:0] m_prev;
  logic [NSRC-1:0] cur_src;
  logic [DW-1:0]   m_last;
  rd_t             rq [$];
  int              cyc;
  int              total;
  int              bad;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_outputs();
    logic          exp_valid;
    logic [NS*DW-1:0] exp_scr;
    exp_valid = 1'b0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      exp_valid = 1'b1;
      m_last    = rq[0].data;
      void'(rq.pop_front());
    end
    check_val("read_valid", bus.read_valid, exp_valid);
    check_val("data_out", bus.data_out, m_last);
    check_val("irq", irq, |(m_reg[0] & m_reg[1]));
    for (int j = 0; j < NS; j++) exp_scr[j*DW +: DW] = m_reg[j+3];
    check_val("scratch_out", scratch_out, exp_scr);
  endtask

  task automatic step(input logic rd, input logic wr, input int addr,
                      input logic [DW/8-1:0] be, input logic [DW-1:0] din);
    logic [DW-1:0] m;
    logic [DW-1:0] rdat;
    reset          = 1'b0;
    bus.read       = rd;
    bus.write      = wr;
    bus.address    = AW'(addr);
    bus.byteenable = be;
    bus.data_in    = din;
    irq_sources    = cur_src;
    for (int b = 0; b < DW/8; b++) m[b*8 +: 8] = {8{be[b]}};
    if (rd && !wr) begin
      rdat = (addr == 2) ? DW'(cur_src) : m_reg[addr];
      rq.push_back('{due: cyc + LAT, data: rdat});
    end
    if (wr) begin
      case (addr)
        0: m_reg[0] = m_reg[0] & ~(din & m);
        1: m_reg[1] = ((m_reg[1] & ~m) | (din & m)) & SRC_MASK;
        2: ;
        default: m_reg[addr] = (m_reg[addr] & ~m) | (din & m);
      endcase
    end
    m_reg[0] = (m_reg[0] | DW'(cur_src & ~m_prev)) & SRC_MASK;
    m_prev   = cur_src;
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 0, '0, '0);
  endtask

  task automatic wr_reg(input int addr, input logic [DW/8-1:0] be, input logic [DW-1:0] din);
    step(1'b0, 1'b1, addr, be, din);
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    irq_sources    = cur_src;
    for (int r = 0; r < REGS; r++) m_reg[r] = '0;
    m_prev = '0;
    m_last = '0;
    rq.delete();
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic read_expect(input string tag, input int addr, input logic [DW-1:0] exp);
    step(1'b1, 1'b0, addr, '0, '0);
    repeat (LAT - 1) idle();
    check_val({tag, "_valid"}, bus.read_valid, 1'b1);
    check_val(tag, bus.data_out, exp);
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    cyc            = 0;
    cur_src        = '0;
    reset          = 1'b1;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.address    = '0;
    bus.byteenable = '0;
    bus.data_in    = '0;
    irq_sources    = '0;

    do_reset();
    do_reset();

    // Every register reads zero after reset.
    for (int r = 0; r < REGS; r++) read_expect("reset_read", r, 32'h0);
    check_val("reset_irq", irq, 1'b0);

    // Byte-enable write to a scratch register.
    wr_reg(4, 4'hF, 32'h11223344);
    wr_reg(4, 4'b0101, 32'hAABBCCDD);
    read_expect("be_read", 4, 32'h11BB33DD);
    check_val("be_scratch", scratch_out[DW +: DW], 32'h11BB33DD);

    // Interrupt flow.
    wr_reg(1, 4'hF, 32'h5);
    cur_src = 4'b0100;
    idle();
    check_val("irq_set", irq, 1'b1);
    cur_src = 4'b0000;
    read_expect("status_after_edge", 0, 32'h4);
    wr_reg(0, 4'hF, 32'h4);
    check_val("irq_w1c", irq, 1'b0);
    cur_src = 4'b0010;
    idle();
    cur_src = 4'b0000;
    read_expect("status_disabled_src", 0, 32'h2);
    check_val("irq_disabled", irq, 1'b0);

    // Rising edge and W1C of the same bit in one cycle: set wins.
    cur_src = 4'b0001;
    wr_reg(0, 4'hF, 32'h1);
    cur_src = 4'b0000;
    read_expect("set_beats_clear", 0, 32'h3);
    check_val("irq_set_beats_clear", irq, 1'b1);
    wr_reg(0, 4'hF, 32'hF);

    // Back-to-back reads return in order on consecutive cycles.
    for (int k = 0; k < 4; k++) wr_reg(3 + k, 4'hF, DW'(k + 1));
    for (int k = 0; k < 6; k++) begin
      if (k < 4) step(1'b1, 1'b0, 3 + k, '0, '0);
      else idle();
      if (k >= 1 && k <= 4) begin
        check_val("pipe_valid", bus.read_valid, 1'b1);
        check_val("pipe_data", bus.data_out, DW'(k));
      end
    end
    check_val("pipe_valid_end", bus.read_valid, 1'b0);

    // Simultaneous read and write: write wins, no read return.
    step(1'b1, 1'b1, 3, 4'hF, 32'h55);
    idle();
    check_val("rw_no_valid", bus.read_valid, 1'b0);
    idle();
    check_val("rw_no_valid2", bus.read_valid, 1'b0);
    read_expect("rw_written", 3, 32'h55);

    // Reset one cycle after a read accept discards the read.
    step(1'b1, 1'b0, 4, '0, '0);
    do_reset();
    check_val("reset_discard", bus.read_valid, 1'b0);
    idle();
    check_val("reset_discard2", bus.read_valid, 1'b0);

    // IRQ_RAW ignores writes and reflects current levels.
    cur_src = 4'b1010;
    idle();
    wr_reg(2, 4'hF, 32'hFFFF_FFFF);
    read_expect("raw_read", 2, 32'hA);
    read_expect("enable_untouched", 1, 32'h0);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) cur_src = NSRC'($urandom);
      if ($urandom_range(0, 199) == 0) do_reset();
      else step(1'($urandom), ($urandom_range(0, 2) == 0), $urandom_range(0, REGS - 1),
                4'($urandom), $urandom);
    end
    repeat (LAT + 1) idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
